// File: rtl/barcode_dest_ctrl.sv
// Station-to-station destination controller: accepts go/stop commands, consumes
// barcode IDs, stops on the matching station, buzzes on arrival, aborts on watchdog.
module barcode_dest_ctrl #(
    parameter int TIMEOUT  = 5_000_000,
    parameter int BUZZ_LEN = 50_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] cmd,
    input  logic       cmd_rdy,
    output logic       clr_cmd_rdy,
    input  logic [7:0] ID,
    input  logic       ID_vld,
    output logic       clr_ID_vld,
    output logic       go,
    output logic [5:0] dest,
    output logic       arrived,
    output logic       timeout,
    output logic       buzz
);

    typedef enum logic [1:0] {IDLE, CMD_CHK, MOVE, ARRIVE} state_t;

    localparam logic [23:0] TMR_LAST  = 24'(TIMEOUT - 1);
    localparam logic [15:0] BUZZ_LAST = 16'(BUZZ_LEN - 1);

    state_t      state;
    logic [7:0]  cmd_q;
    logic [23:0] timer;
    logic [15:0] buzz_cnt;
    logic        id_match;
    logic        unused_id_hi;

    assign unused_id_hi = ^ID[7:6];
    assign id_match     = (ID[5:0] == dest);

    assign go          = (state == MOVE);
    assign clr_cmd_rdy = (state == CMD_CHK);
    assign buzz        = (state == ARRIVE);

    // A pending command always outranks an ID in IDLE/MOVE, leaving the ID for later.
    // Gated by rst_n so no acknowledge escapes while held in reset.
    assign clr_ID_vld = rst_n & ID_vld &
                        (((state == IDLE || state == MOVE) && !cmd_rdy) ||
                         (state == ARRIVE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cmd_q    <= '0;
            dest     <= '0;
            timer    <= '0;
            buzz_cnt <= '0;
            timeout  <= 1'b0;
            arrived  <= 1'b0;
        end else begin
            arrived <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_rdy) begin
                        cmd_q <= cmd;
                        state <= CMD_CHK;
                    end
                end
                CMD_CHK: begin
                    // Only opcode 01 moves; stop and illegal opcodes both fall back to IDLE
                    if (cmd_q[7:6] == 2'b01) begin
                        dest    <= cmd_q[5:0];
                        timer   <= '0;
                        timeout <= 1'b0;
                        state   <= MOVE;
                    end else begin
                        state <= IDLE;
                    end
                end
                MOVE: begin
                    if (cmd_rdy) begin
                        cmd_q <= cmd;
                        state <= CMD_CHK;
                    end else if (ID_vld) begin
                        timer <= '0;
                        if (id_match) begin
                            buzz_cnt <= BUZZ_LAST;
                            arrived  <= 1'b1;
                            state    <= ARRIVE;
                        end
                    end else if (timer == TMR_LAST) begin
                        timeout <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        timer <= timer + 24'd1;
                    end
                end
                ARRIVE: begin
                    if (buzz_cnt == 16'd0) state <= IDLE;
                    else                   buzz_cnt <= buzz_cnt - 16'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/barcode_dest_ctrl.md
Name: barcode_dest_ctrl

Overview:
- Sequences the barcode reader for a station-to-station follower.
- Accepts "go to station N" / "stop" commands from the host command interface and drives go to the motion logic.
- Consumes every ID/ID_vld from barcode_2 and pulses its clr_ID_vld; stops on the matching station ID, then signals arrival.
- A watchdog stops motion if no barcode is seen within TIMEOUT cycles.

Parameters:
- TIMEOUT, default 5_000_000: cycles in MOVE without any accepted ID before the timeout abort. Range 2..2^24-1.
- BUZZ_LEN, default 50_000: cycles buzz is held high after arrival. Range 1..2^16-1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cmd  in  8  host command: [7:6] opcode (01 = go, 00 = stop, 1x = illegal), [5:0] station number
- cmd_rdy  in  1  command valid; level held by the host until clr_cmd_rdy
- clr_cmd_rdy  out  1  one-cycle acknowledge of cmd
- ID  in  8  station ID from barcode_2; only [5:0] is compared
- ID_vld  in  1  ID valid level from barcode_2
- clr_ID_vld  out  1  one-cycle acknowledge to barcode_2
- go  out  1  motion enable
- dest  out  6  latched destination station
- arrived  out  1  one-cycle pulse on reaching dest
- timeout  out  1  sticky watchdog error flag
- buzz  out  1  arrival buzzer enable

Behaviour:
- Reset (async, rst_n low): state=IDLE, dest=0, timer=0, buzz counter=0, timeout=0. All outputs 0. Reset mid-move drops go in the same reset assertion, with no cycle delay.
- States: IDLE, CMD_CHK, MOVE, ARRIVE. The state is a registered FSM.
- Output decode from the state register: go = (state==MOVE); clr_cmd_rdy = (state==CMD_CHK); buzz = (state==ARRIVE).
- arrived is registered and high for exactly the first cycle in ARRIVE.
- clr_ID_vld is combinational (Mealy). It is high in any cycle where ID_vld=1 and the FSM consumes or discards the ID (rules below). ID_vld drops the next cycle, so the pulse is exactly one cycle.
- IDLE:
  - cmd_rdy=1 -> latch cmd into an internal register, go to CMD_CHK.
  - Otherwise, ID_vld=1 -> discard the ID (clr_ID_vld=1) and stay in IDLE.
- CMD_CHK (exactly 1 cycle; clr_cmd_rdy=1):
  - opcode 01: dest <= cmd[5:0], timer <= 0, timeout <= 0 -> MOVE.
  - opcode 00 or 1x -> IDLE. The illegal opcode is treated as stop; dest and timeout are unchanged.
- MOVE, priority cmd_rdy > ID_vld > watchdog:
  - cmd_rdy=1 -> latch cmd -> CMD_CHK. A pending ID stays un-acked and is handled afterwards.
  - Else ID_vld=1: clr_ID_vld=1 and timer <= 0.
    - ID[5:0]==dest -> ARRIVE. The buzz counter is loaded with BUZZ_LEN-1.
    - Mismatch -> stay in MOVE.
  - Else timer==TIMEOUT-1 -> timeout <= 1 -> IDLE. go falls the next cycle.
  - Else timer <= timer+1.
  - The timer is 24-bit and never wraps: TIMEOUT is reached first.
- ARRIVE:
  - The buzz counter decrements each cycle; at 0 -> IDLE. buzz is therefore high for exactly BUZZ_LEN cycles.
  - cmd_rdy is ignored: not acked, remains pending, and is serviced in IDLE.
  - ID_vld=1 is discarded (clr_ID_vld=1).
- Latency: go rises 2 cycles after cmd_rdy is first sampled high in IDLE (IDLE->CMD_CHK->MOVE). go falls 1 cycle after a matching ID_vld is sampled.
- Simultaneous cmd_rdy and matching ID_vld in MOVE: the command wins and the ID is not consumed. After CMD_CHK, if the new command is go, the pending ID is compared against the new dest.

Test Plan (TIMEOUT=100, BUZZ_LEN=8):
- Go command: cmd=8'h45, cmd_rdy pulse held until ack -> clr_cmd_rdy high for 1 cycle, 1 cycle after cmd_rdy is sampled; dest=5, go=1 two cycles after cmd_rdy is sampled; timeout=0.
- Mismatch then match: in MOVE, ID=8'h03 with ID_vld, then ID=8'h05 -> clr_ID_vld one-cycle pulse for each. First ID: go stays 1. Second ID: go=0 next cycle, arrived pulse 1 cycle, buzz high for exactly 8 cycles, then IDLE.
- Watchdog: go to station 5, no ID for 100 cycles -> timeout=1, go=0. A later cmd=8'h42 -> timeout cleared in CMD_CHK, go=1, dest=2.
- Preemption: in MOVE, cmd=8'h00 and ID=8'h05 (matching) asserted in the same cycle -> clr_cmd_rdy pulses, clr_ID_vld stays 0 that cycle, state returns to IDLE with arrived=0. In IDLE the pending ID is discarded with clr_ID_vld.
- Illegal opcode and ARRIVE hold-off: cmd=8'hC7 while moving -> go=0, dest unchanged. A cmd_rdy raised during ARRIVE is acked only after buzz ends.
- Async reset in MOVE at an arbitrary cycle -> go, buzz, timeout, dest all 0 immediately. No clr_* pulse until reset is released.
